// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch sequencer
package fetch_pkg;

  localparam int IW_DEF  = 16;
  localparam int AW_DEF  = 5;
  localparam int PCW_DEF = 16;
  localparam logic [3:0] HALT_OP_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [PCW_DEF-1:0] pc;
    logic [IW_DEF-1:0]  ins;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small prefetch FIFO with flush, count and zeroed head when empty
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output logic [W-1:0]  head_data
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush wins over a same-cycle push: the pushed word is dropped with the rest.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and fetch control feeding decode through a prefetch queue
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int             IW       = IW_DEF,
  parameter int             AW       = AW_DEF,
  parameter int             PCW      = PCW_DEF,
  parameter int             DEPTH    = 2,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter logic [3:0]     HALT_OP  = HALT_OP_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           redirect_valid,
  input  logic [PCW-1:0] redirect_pc,
  output logic [AW-1:0]  imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           ins_valid,
  output logic [IW-1:0]  ins_data,
  output logic [PCW-1:0] ins_pc,
  input  logic           ins_ready,
  output logic [PCW-1:0] pc,
  output logic           busy,
  output logic           halted
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t         state;
  state_t         state_nx;
  logic [PCW-1:0] pc_nx;
  logic [CW-1:0]  count;
  logic           pop;
  logic           flush;
  logic           fetch;
  logic           halt_hit;

  assign pop      = ins_valid && ins_ready;
  assign flush    = redirect_valid && (state != IDLE);
  // A pop frees a slot in the same cycle, so a full queue still streams at one word per cycle.
  assign fetch    = (state == RUN) && !redirect_valid && ((count < CW'(DEPTH)) || pop);
  assign halt_hit = (imem_data[IW-1 -: 4] == HALT_OP);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          pc_nx    = RESET_PC;
        end
      end
      RUN, HALT: begin
        if (redirect_valid) begin
          state_nx = RUN;
          pc_nx    = redirect_pc;
        end else if (fetch) begin
          if (halt_hit) state_nx = HALT;
          else          pc_nx    = pc + PCW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  fetch_queue #(
    .W     (PCW + IW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (fetch),
    .push_data  ({pc, imem_data}),
    .pop        (pop),
    .count      (count),
    .head_valid (ins_valid),
    .head_data  ({ins_pc, ins_data})
  );

  assign imem_addr = pc[AW-1:0];
  assign busy      = (state != IDLE);
  assign halted    = (state == HALT) && (count == '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a queue-based model
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [4:0]  imem_addr;
  logic [15:0] imem_data;
  logic        ins_valid;
  logic [15:0] ins_data;
  logic [15:0] ins_pc;
  logic        ins_ready;
  logic [15:0] pc;
  logic        busy;
  logic        halted;

  logic [15:0] mem [32];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .pc             (pc),
    .busy           (busy),
    .halted         (halted)
  );

  // Reference model: a list of delivered-but-unconsumed words, the fetch pointer and a mode.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mpc;
  int          mst;

  wire [55:0] dut_vec = {ins_valid, ins_data, ins_pc, pc, busy, halted, imem_addr};

  function automatic logic [55:0] exp_vec();
    ent_t h;
    logic v;
    h = '0;
    v = (mq.size() > 0);
    if (v) h = mq[0];
    return {v, h.ins, h.pc, mpc, (mst != 0), (mst == 2 && !v), mpc[4:0]};
  endfunction

  task automatic tick();
    int   sz;
    logic popped;
    ent_t e;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      mpc = 16'h0000;
      mst = 0;
    end else begin
      popped = (sz > 0) && ins_ready;
      if (popped) void'(mq.pop_front());
      if (mst == 0) begin
        if (start) begin
          mpc = 16'h0000;
          mst = 1;
        end
      end else if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc;
        mst = 1;
      end else if (mst == 1 && (sz < 2 || popped)) begin
        e.pc  = mpc;
        e.ins = mem[mpc[4:0]];
        mq.push_back(e);
        if (e.ins[15:12] == 4'hF) mst = 2;
        else                      mpc = mpc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_model dut=%h exp=%h", dut_vec, exp_vec());
    end
    vectors++;
    if ({ins_valid, ins_data, ins_pc, pc, busy, halted} !== {1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state v=%b d=%h p=%h pc=%h busy=%b halted=%b required all zero",
               ins_valid, ins_data, ins_pc, pc, busy, halted);
    end
  endtask

  task automatic test_stream();
    reset = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, ins_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stream_start busy=%b ins_valid=%b required 1 0", busy, ins_valid);
    end
    tick();
    vectors++;
    if ({ins_valid, ins_pc, ins_data} !== {1'b1, 16'h0000, 16'h1000}) begin
      miscompares++;
      $display("FAIL stream_first v=%b pc=%h d=%h required 1 0000 1000", ins_valid, ins_pc, ins_data);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if ({ins_valid, ins_pc, ins_data} !== {1'b1, 16'(k), 16'h1000 + 16'(k)}) begin
        miscompares++;
        $display("FAIL stream_seq k=%0d pc=%h d=%h", k, ins_pc, ins_data);
      end
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL stream_model dut=%h exp=%h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    ins_ready = 1'b0;
    restart();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({ins_valid, ins_pc, ins_data, pc} !== {1'b1, 16'h0000, 16'h1000, 16'h0002}) begin
        miscompares++;
        $display("FAIL bp_hold k=%0d pc_head=%h d=%h pc=%h required 0000 1000 0002", k, ins_pc, ins_data, pc);
      end
    end
    ins_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({ins_valid, ins_pc, ins_data} !== {1'b1, 16'(k), 16'h1000 + 16'(k)}) begin
        miscompares++;
        $display("FAIL bp_release k=%0d pc=%h d=%h", k, ins_pc, ins_data);
      end
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_model dut=%h exp=%h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_halt();
    int got[$];
    mem[3] = 16'hF000;
    ins_ready = 1'b1;
    restart();
    for (int k = 0; k < 12; k++) begin
      if (ins_valid && ins_ready) got.push_back(int'(ins_pc));
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL halt_model k=%0d dut=%h exp=%h", k, dut_vec, exp_vec());
      end
      tick();
    end
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL halt_count delivered=%0d required 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (got[k] != k) begin
          miscompares++;
          $display("FAIL halt_order idx=%0d pc=%0d required %0d", k, got[k], k);
        end
      end
    end
    vectors++;
    if ({halted, ins_valid, pc, busy} !== {1'b1, 1'b0, 16'h0003, 1'b1}) begin
      miscompares++;
      $display("FAIL halt_state halted=%b v=%b pc=%h busy=%b required 1 0 0003 1", halted, ins_valid, pc, busy);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if ({halted, busy, pc} !== {1'b0, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL halt_resume halted=%b busy=%b pc=%h required 0 1 0000", halted, busy, pc);
    end
    tick();
    vectors++;
    if ({ins_valid, ins_pc, ins_data} !== {1'b1, 16'h0000, 16'h1000}) begin
      miscompares++;
      $display("FAIL halt_refetch v=%b pc=%h d=%h required 1 0000 1000", ins_valid, ins_pc, ins_data);
    end
    mem[3] = 16'h1003;
  endtask

  task automatic test_redirect();
    ins_ready = 1'b1;
    restart();
    for (int k = 0; k < 3; k++) tick();
    ins_ready = 1'b0;
    tick();
    vectors++;
    if ({pc, ins_valid} !== {16'h0005, 1'b1}) begin
      miscompares++;
      $display("FAIL redir_setup pc=%h v=%b required 0005 1", pc, ins_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0014;
    tick();
    redirect_valid = 1'b0;
    vectors++;
    if ({ins_valid, pc} !== {1'b0, 16'h0014}) begin
      miscompares++;
      $display("FAIL redir_flush v=%b pc=%h required 0 0014", ins_valid, pc);
    end
    tick();
    vectors++;
    if ({ins_valid, ins_pc, ins_data} !== {1'b1, 16'h0014, 16'h1014}) begin
      miscompares++;
      $display("FAIL redir_target v=%b pc=%h d=%h required 1 0014 1014", ins_valid, ins_pc, ins_data);
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL redir_model dut=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_wrap();
    ins_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h001F;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++;
    if ({ins_pc, ins_data, imem_addr} !== {16'h001F, 16'h101F, 5'd0}) begin
      miscompares++;
      $display("FAIL wrap_31 pc=%h d=%h addr=%h required 001F 101F 00", ins_pc, ins_data, imem_addr);
    end
    tick();
    vectors++;
    if ({ins_pc, ins_data} !== {16'h0020, 16'h1000}) begin
      miscompares++;
      $display("FAIL wrap_32 pc=%h d=%h required 0020 1000", ins_pc, ins_data);
    end
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++;
    if ({ins_pc, ins_data, pc} !== {16'hFFFF, 16'h101F, 16'h0000}) begin
      miscompares++;
      $display("FAIL wrap_pc pc_head=%h d=%h pc=%h required FFFF 101F 0000", ins_pc, ins_data, pc);
    end
  endtask

  task automatic test_reset_mid();
    ins_ready = 1'b1;
    restart();
    for (int k = 0; k < 20 && pc != 16'h0006; k++) tick();
    ins_ready = 1'b0;
    tick();
    vectors++;
    if ({pc, ins_valid} !== {16'h0007, 1'b1}) begin
      miscompares++;
      $display("FAIL rmid_setup pc=%h v=%b required 0007 1", pc, ins_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({ins_valid, pc, busy} !== {1'b0, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL rmid_reset v=%b pc=%h busy=%b required 0 0000 0", ins_valid, pc, busy);
    end
    ins_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({ins_valid, pc, busy} !== {1'b0, 16'h0000, 1'b0}) begin
        miscompares++;
        $display("FAIL rmid_idle k=%0d v=%b pc=%h busy=%b required 0 0000 0", k, ins_valid, pc, busy);
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      start          = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      ins_ready      = ($urandom_range(0, 3) != 0);
      tick();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random n=%0d dut=%h exp=%h", n, dut_vec, exp_vec());
      end
    end
    reset = 1'b0; start = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
    mpc = '0; mst = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
